// File: rtl/hidden_unit_mac_if.sv
// Bus bundle for the hidden-unit MAC: start/bias, beat stream in, result out.
interface hidden_unit_mac_if #(
    parameter int unsigned WBITS = 8
);
    logic             start;
    logic [WBITS-1:0] bias;
    logic             in_valid;
    logic             in_ready;
    logic             v_bit;
    logic [WBITS-1:0] w;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      sum;
    logic             busy;

    // Producer/consumer side (streamer, sigmoid stage, or bench)
    modport master (
        output start, bias, in_valid, v_bit, w, out_ready,
        input  in_ready, out_valid, sum, busy
    );

    // MAC side
    modport slave (
        input  start, bias, in_valid, v_bit, w, out_ready,
        output in_ready, out_valid, sum, busy
    );
endinterface

// File: rtl/hidden_unit_mac.sv
// Serial multiply-accumulate for one RBM hidden unit: bias + sum(v_i * w_i) over NV
// binary visible units, saturated to Q8.4 and sign-extended to a 16-bit word.
module hidden_unit_mac #(
    parameter int unsigned NV    = 16,
    parameter int unsigned WBITS = 8,
    parameter int unsigned ACC_W = 16
) (
    input logic              clk,
    input logic              rst_n,
    hidden_unit_mac_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_t;

    localparam logic [7:0]              CntLast = 8'(NV - 1);
    localparam logic signed [ACC_W-1:0] SatHi   = ACC_W'(2047);
    localparam logic signed [ACC_W-1:0] SatLo   = ~SatHi;  // -2048

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic [7:0]              cnt_q, cnt_d;
    logic [15:0]             sum_q, sum_d;
    logic [15:0]             sum_sat;
    logic                    beat;

    assign w_ext    = {{(ACC_W - WBITS){bus.w[WBITS-1]}}, bus.w};
    assign bias_ext = {{(ACC_W - WBITS){bus.bias[WBITS-1]}}, bus.bias};
    assign beat     = bus.in_valid && (state_q == StAcc);

    // Status outputs decode directly from the registered state
    assign bus.in_ready  = (state_q == StAcc);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.sum       = sum_q;

    // Accumulate the current beat and clamp to the 12-bit Q8.4 range
    always_comb begin
        acc_next = acc_q + (bus.v_bit ? w_ext : '0);
        if (acc_next > SatHi) begin
            sum_sat = 16'h07FF;
        end else if (acc_next < SatLo) begin
            sum_sat = 16'hF800;
        end else begin
            sum_sat = {{4{acc_next[11]}}, acc_next[11:0]};
        end
    end

    // Next-state logic: start in IDLE, NV accepted beats in ACC, hold result in DONE
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StAcc;
                    acc_d   = bias_ext;
                    cnt_d   = 8'd0;
                end
            end
            StAcc: begin
                if (beat) begin
                    acc_d = acc_next;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CntLast) begin
                        state_d = StDone;
                        sum_d   = sum_sat;
                    end
                end
            end
            StDone: begin
                // start is deliberately ignored here, even alongside out_ready
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
        end
    end
endmodule

// File: tb/tb_hidden_unit_mac.sv
// Scoreboard bench for hidden_unit_mac: one NV=4 and one NV=16 instance.
module tb_hidden_unit_mac;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hidden_unit_mac_if #(.WBITS(8)) b4 ();
    hidden_unit_mac_if #(.WBITS(8)) b16 ();

    hidden_unit_mac #(.NV(4), .WBITS(8), .ACC_W(16)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4.slave)
    );

    hidden_unit_mac #(.NV(16), .WBITS(8), .ACC_W(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16.slave)
    );

    int total = 0;
    int bad   = 0;
    int done4 = 0;
    int done16 = 0;
    logic [15:0] q4[$];
    logic [15:0] q16[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitors: pop and compare on every output handshake
    always @(negedge clk) begin
        if (rst_n === 1'b1 && b4.out_valid === 1'b1 && b4.out_ready === 1'b1) begin
            if (q4.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon4_unexpected: got %h expected no output", b4.sum);
            end else begin
                check("mon4_sum", b4.sum, q4.pop_front());
            end
            done4++;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && b16.out_valid === 1'b1 && b16.out_ready === 1'b1) begin
            if (q16.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon16_unexpected: got %h expected no output", b16.sum);
            end else begin
                check("mon16_sum", b16.sum, q16.pop_front());
            end
            done16++;
        end
    end

    // One-cycle start pulse; optionally push the expected result
    task automatic do_start(input bit big, input logic [7:0] b, input logic [15:0] exp,
                            input bit push);
        if (big) begin
            b16.start = 1'b1;
            b16.bias  = b;
            if (push) q16.push_back(exp);
        end else begin
            b4.start = 1'b1;
            b4.bias  = b;
            if (push) q4.push_back(exp);
        end
        @(posedge clk);
        #1;
        b16.start = 1'b0;
        b4.start  = 1'b0;
    endtask

    // Present one beat and hold it until accepted (bounded)
    task automatic do_beat(input bit big, input logic v, input logic [7:0] wt);
        bit ok;
        ok = 1'b0;
        if (big) begin
            b16.in_valid = 1'b1; b16.v_bit = v; b16.w = wt;
        end else begin
            b4.in_valid = 1'b1; b4.v_bit = v; b4.w = wt;
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (big ? b16.in_ready : b4.in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        b16.in_valid = 1'b0;
        b4.in_valid  = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: in_ready stayed 0, expected 1");
        end
    endtask

    // Wait (bounded) for the monitor to count a given number of results
    task automatic wait_out(input bit big, input int target);
        int n;
        n = 0;
        while ((big ? done16 : done4) < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if ((big ? done16 : done4) < target) begin
            total++;
            bad++;
            $display("FAIL wait_out_timeout: got %0d results expected %0d",
                     big ? done16 : done4, target);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        b4.start = 0;  b4.bias = 0;  b4.in_valid = 0;  b4.v_bit = 0;  b4.w = 0;  b4.out_ready = 0;
        b16.start = 0; b16.bias = 0; b16.in_valid = 0; b16.v_bit = 0; b16.w = 0; b16.out_ready = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("rst4_out_valid", b4.out_valid, 1'b0);
        check_bit("rst4_in_ready", b4.in_ready, 1'b0);
        check_bit("rst4_busy", b4.busy, 1'b0);
        check("rst4_sum", b4.sum, 16'h0000);
        check_bit("rst16_out_valid", b16.out_valid, 1'b0);
        check_bit("rst16_busy", b16.busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // T1: 16 + 16 + 8 + 0 - 16 = 24
        b4.out_ready = 1'b1;
        do_start(1'b0, 8'h10, 16'h0018, 1'b1);
        check_bit("t1_in_ready", b4.in_ready, 1'b1);
        do_beat(1'b0, 1'b1, 8'h10);
        do_beat(1'b0, 1'b1, 8'h08);
        do_beat(1'b0, 1'b0, 8'h7F);
        check_bit("t1_no_early_valid", b4.out_valid, 1'b0);
        do_beat(1'b0, 1'b1, 8'hF0);
        check_bit("t1_valid_latency", b4.out_valid, 1'b1);
        check_bit("t1_in_ready_low", b4.in_ready, 1'b0);
        wait_out(1'b0, 1);
        check_bit("t1_idle_after", b4.busy, 1'b0);

        // T2: 127 * 17 = 2159 -> positive saturation
        b16.out_ready = 1'b1;
        do_start(1'b1, 8'h7F, 16'h07FF, 1'b1);
        for (int i = 0; i < 16; i++) do_beat(1'b1, 1'b1, 8'h7F);
        wait_out(1'b1, 1);

        // T3: -128 * 17 = -2176 -> negative saturation
        do_start(1'b1, 8'h80, 16'hF800, 1'b1);
        for (int i = 0; i < 16; i++) do_beat(1'b1, 1'b1, 8'h80);
        wait_out(1'b1, 2);

        // T4: bubbles on input, consumer stalls 5 cycles, start pulsed in DONE
        b4.out_ready = 1'b0;
        do_start(1'b0, 8'h10, 16'h0018, 1'b1);
        do_beat(1'b0, 1'b1, 8'h10);
        @(posedge clk); #1;
        do_beat(1'b0, 1'b1, 8'h08);
        @(posedge clk); #1;
        do_beat(1'b0, 1'b0, 8'h7F);
        @(posedge clk); #1;
        do_beat(1'b0, 1'b1, 8'hF0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_bit("t4_hold_valid", b4.out_valid, 1'b1);
            check("t4_hold_sum", b4.sum, 16'h0018);
            @(posedge clk);
            #1;
            b4.start = (i == 1);
            b4.bias  = 8'h55;
        end
        b4.start = 1'b0;
        check_bit("t4_still_done", b4.busy, 1'b1);
        b4.out_ready = 1'b1;
        b4.start     = 1'b1;
        @(posedge clk);
        #1;
        b4.start = 1'b0;
        check("t4_handshakes", 16'(done4), 16'd2);
        check_bit("t4_start_ignored_busy", b4.busy, 1'b0);
        check_bit("t4_out_valid_drop", b4.out_valid, 1'b0);

        // T5: reset after 3 beats aborts the accumulation
        do_start(1'b0, 8'h10, 16'h0000, 1'b0);
        do_beat(1'b0, 1'b1, 8'h10);
        do_beat(1'b0, 1'b1, 8'h08);
        do_beat(1'b0, 1'b0, 8'h7F);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_bit("t5_out_valid", b4.out_valid, 1'b0);
        check_bit("t5_in_ready", b4.in_ready, 1'b0);
        check_bit("t5_busy", b4.busy, 1'b0);
        check("t5_sum", b4.sum, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_start(1'b0, 8'h10, 16'h0018, 1'b1);
        do_beat(1'b0, 1'b1, 8'h10);
        do_beat(1'b0, 1'b1, 8'h08);
        do_beat(1'b0, 1'b0, 8'h7F);
        do_beat(1'b0, 1'b1, 8'hF0);
        wait_out(1'b0, 3);

        // T6: back-to-back transactions, second has all v=0 -> bias only (-16)
        do_start(1'b0, 8'h10, 16'h0018, 1'b1);
        do_beat(1'b0, 1'b1, 8'h10);
        do_beat(1'b0, 1'b1, 8'h08);
        do_beat(1'b0, 1'b0, 8'h7F);
        do_beat(1'b0, 1'b1, 8'hF0);
        check_bit("t6_first_valid", b4.out_valid, 1'b1);
        @(posedge clk);
        #1;
        check_bit("t6_idle_after_hs", b4.busy, 1'b0);
        do_start(1'b0, 8'hF0, 16'hFFF0, 1'b1);
        do_beat(1'b0, 1'b0, 8'h33);
        do_beat(1'b0, 1'b0, 8'h7F);
        do_beat(1'b0, 1'b0, 8'h80);
        check_bit("t6_no_early_valid", b4.out_valid, 1'b0);
        do_beat(1'b0, 1'b0, 8'h01);
        check_bit("t6_second_valid", b4.out_valid, 1'b1);
        wait_out(1'b0, 5);

        check("sb_empty4", 16'(q4.size()), 16'd0);
        check("sb_empty16", 16'(q16.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
